// File: rtl/gcd_host_sequencer_pkg.sv
// Shared definitions for the GCD host sequencer: sequencer state encoding and default widths.
package gcd_host_sequencer_pkg;

  localparam int GCD_WIDTH   = 16;
  localparam int GCD_TIMEOUT = 131072;
  localparam int GCD_TO_W    = 18;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FLUSH  = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

endpackage

// File: rtl/gcd_timeout_ctr.sv
// Clear/enable cycle counter with a terminal-count flag raised at TIMEOUT-1.
module gcd_timeout_ctr #(
  parameter int TO_W    = 18,
  parameter int TIMEOUT = 131072
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [TO_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tc = (cnt_reg == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/gcd_host_sequencer.sv
// Operand-load initiator for the GCD core: loads A then B, waits for done or timeout,
// flushes the core and returns the result on a valid/ready output.
module gcd_host_sequencer
  import gcd_host_sequencer_pkg::*;
#(
  parameter int WIDTH   = GCD_WIDTH,
  parameter int TIMEOUT = GCD_TIMEOUT,
  parameter int TO_W    = GCD_TO_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err,
  output logic             core_rst,
  output logic             core_start,
  output logic [WIDTH-1:0] core_data,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             err_reg, err_next;
  logic [WIDTH-1:0] core_data_reg, core_data_next;
  logic             in_ready_reg, out_valid_reg, core_start_reg, flush_reg;
  logic             to_tc;

  gcd_timeout_ctr #(
    .TO_W   (TO_W),
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk(clk),
    .rst(rst),
    .clr(state_reg != ST_WAIT),
    .en (state_reg == ST_WAIT),
    .tc (to_tc)
  );

  always_comb begin
    state_next     = state_reg;
    b_next         = b_reg;
    result_next    = result_reg;
    err_next       = err_reg;
    core_data_next = '0;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          b_next = in_b;
          if (in_a != '0 && in_b != '0) begin
            state_next     = ST_LOAD_A;
            core_data_next = in_a;
          end else begin
            // Zero operand: gcd is the other operand, core is never started
            state_next  = ST_RESP;
            result_next = in_a | in_b;
            err_next    = (in_a == '0) && (in_b == '0);
          end
        end
      end
      ST_LOAD_A: begin
        state_next     = ST_LOAD_B;
        core_data_next = b_reg;
      end
      ST_LOAD_B: state_next = ST_WAIT;
      ST_WAIT: begin
        // Done takes priority over a coincident timeout
        if (core_done) begin
          state_next  = ST_FLUSH;
          result_next = core_result;
          err_next    = 1'b0;
        end else if (to_tc) begin
          state_next  = ST_FLUSH;
          result_next = '0;
          err_next    = 1'b1;
        end
      end
      ST_FLUSH: state_next = ST_RESP;
      ST_RESP: begin
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      b_reg          <= '0;
      result_reg     <= '0;
      err_reg        <= 1'b0;
      core_data_reg  <= '0;
      in_ready_reg   <= 1'b1;
      out_valid_reg  <= 1'b0;
      core_start_reg <= 1'b0;
      flush_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      b_reg          <= b_next;
      result_reg     <= result_next;
      err_reg        <= err_next;
      core_data_reg  <= core_data_next;
      in_ready_reg   <= (state_next == ST_IDLE);
      out_valid_reg  <= (state_next == ST_RESP);
      core_start_reg <= (state_next == ST_LOAD_A);
      flush_reg      <= (state_next == ST_FLUSH);
    end
  end

  assign in_ready   = in_ready_reg;
  assign out_valid  = out_valid_reg;
  assign out_result = result_reg;
  assign out_err    = err_reg;
  assign core_start = core_start_reg;
  assign core_data  = core_data_reg;
  // The core follows the system reset as well as the post-job flush pulse
  assign core_rst   = rst | flush_reg;

endmodule
